updown_counter_bounded: RTL and testbench

- Parametrised successor to the team's 4-bit load/enable up/down counter.
- Adds configurable width, runtime-programmable lower and upper bounds, and a programmable step size.
- Terminal behaviour is selectable per instance: wrap or saturate.
- Provides boundary flags and one-cycle overflow/underflow event pulses for sequencing and timer logic.

---
 rtl/updown_counter_bounded.sv | 131 +++++++++++++
 tb/tb_updown_counter_bounded.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_bounded.sv
// updown_counter_bounded
//
// Parametrised up/down counter. Its lower and upper bounds and its step size
// can be changed at runtime. At a bound the counter either wraps or
// saturates; SATURATE selects which, per instance.
//
// Parameters:
//   WIDTH       - width of the count, load value, step and bound buses
//   SATURATE    - 0: wrap at the bounds, 1: clamp at the bounds
//   RESET_VALUE - value of count after reset
//
// Ports:
//   clk         - clock; state updates on the rising edge
//   rst         - asynchronous active-low reset
//   enable      - count step enable
//   up          - 1: count up, 0: count down
//   count_load  - synchronous load request; it wins over enable
//   load_value  - value to load, clamped into [min_value, max_value]
//   step        - increment/decrement magnitude
//   min_value   - inclusive lower bound
//   max_value   - inclusive upper bound
//   count       - registered count
//   at_min      - count == min_value (combinational)
//   at_max      - count == max_value (combinational)
//   ovf         - registered one-cycle pulse on an upward bound crossing
//   unf         - registered one-cycle pulse on a downward bound crossing
//   cfg_err     - min_value > max_value (combinational); the counter freezes

module updown_counter_bounded #(
    parameter int unsigned      WIDTH       = 8,
    parameter bit               SATURATE    = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up,
    input  logic             count_load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] min_value,
    input  logic [WIDTH-1:0] max_value,
    output logic [WIDTH-1:0] count,
    output logic             at_min,
    output logic             at_max,
    output logic             ovf,
    output logic             unf,
    output logic             cfg_err
);

    // Operands widened by one bit so that sums never truncate.
    logic [WIDTH:0] count_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] min_x;
    logic [WIDTH:0] max_x;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] down_floor;

    assign count_x    = {1'b0, count};
    assign step_x     = {1'b0, step};
    assign min_x      = {1'b0, min_value};
    assign max_x      = {1'b0, max_value};
    assign up_sum     = count_x + step_x;
    // count - step >= min is rewritten as count >= min + step, which avoids a borrow.
    assign down_floor = min_x + step_x;

    assign at_min  = (count == min_value);
    assign at_max  = (count == max_value);
    assign cfg_err = (min_value > max_value);

    logic [WIDTH-1:0] count_next;
    logic             ovf_next;
    logic             unf_next;

    always_comb begin
        count_next = count;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (!cfg_err) begin
            if (count_load) begin
                if (load_value < min_value) begin
                    count_next = min_value;
                end else if (load_value > max_value) begin
                    count_next = max_value;
                end else begin
                    count_next = load_value;
                end
            end else if (enable && (step != '0)) begin
                if (up) begin
                    if (count > max_value) begin
                        // The bounds moved under the counter: pull it back in silently.
                        count_next = max_value;
                    end else if (up_sum <= max_x) begin
                        count_next = up_sum[WIDTH-1:0];
                    end else if (SATURATE) begin
                        count_next = max_value;
                        ovf_next   = (count != max_value);
                    end else begin
                        count_next = min_value;
                        ovf_next   = 1'b1;
                    end
                end else begin
                    if (count < min_value) begin
                        count_next = min_value;
                    end else if (count_x >= down_floor) begin
                        count_next = count - step;
                    end else if (SATURATE) begin
                        count_next = min_value;
                        unf_next   = (count != min_value);
                    end else begin
                        count_next = max_value;
                        unf_next   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= RESET_VALUE;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
            unf   <= unf_next;
        end
    end

endmodule

// File: tb/tb_updown_counter_bounded.sv
// tb_updown_counter_bounded
//
// Drives one wrap-mode instance and one saturate-mode instance of
// updown_counter_bounded from the same inputs. The expected values in the
// vectors were worked out by hand. Outputs are sampled 1 time unit after
// each rising edge.

module tb_updown_counter_bounded;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             up;
    logic             count_load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] min_value;
    logic [WIDTH-1:0] max_value;

    logic [WIDTH-1:0] count_w;
    logic             at_min_w;
    logic             at_max_w;
    logic             ovf_w;
    logic             unf_w;
    logic             cfg_err_w;

    logic [WIDTH-1:0] count_s;
    logic             at_min_s;
    logic             at_max_s;
    logic             ovf_s;
    logic             unf_s;
    logic             cfg_err_s;

    int n_checks;
    int n_errors;

    updown_counter_bounded #(
        .WIDTH       (WIDTH),
        .SATURATE    (1'b0),
        .RESET_VALUE (8'd0)
    ) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .up         (up),
        .count_load (count_load),
        .load_value (load_value),
        .step       (step),
        .min_value  (min_value),
        .max_value  (max_value),
        .count      (count_w),
        .at_min     (at_min_w),
        .at_max     (at_max_w),
        .ovf        (ovf_w),
        .unf        (unf_w),
        .cfg_err    (cfg_err_w)
    );

    updown_counter_bounded #(
        .WIDTH       (WIDTH),
        .SATURATE    (1'b1),
        .RESET_VALUE (8'd0)
    ) u_sat (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .up         (up),
        .count_load (count_load),
        .load_value (load_value),
        .step       (step),
        .min_value  (min_value),
        .max_value  (max_value),
        .count      (count_s),
        .at_min     (at_min_s),
        .at_max     (at_max_s),
        .ovf        (ovf_s),
        .unf        (unf_s),
        .cfg_err    (cfg_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clocked load with enable off.
    task automatic do_load(input logic [WIDTH-1:0] val);
        count_load = 1'b1;
        enable     = 1'b0;
        load_value = val;
        tick();
        count_load = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        enable     = 1'b0;
        up         = 1'b1;
        count_load = 1'b0;
        load_value = '0;
        step       = 8'd3;
        min_value  = 8'd2;
        max_value  = 8'd10;

        // Reset state
        #12;
        check_eq("rst_count_w", count_w, 0);
        check_eq("rst_count_s", count_s, 0);
        check_eq("rst_ovf", ovf_w, 0);
        check_eq("rst_unf", unf_w, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Wrap up: 5 -> 8 -> 2 (ovf) -> 5
        do_load(8'd5);
        check_eq("load5_w", count_w, 5);
        enable = 1'b1;
        up     = 1'b1;
        tick();
        check_eq("up1_count", count_w, 8);
        check_eq("up1_ovf", ovf_w, 0);
        check_eq("up1_at_max", at_max_w, 0);
        tick();
        check_eq("up2_count", count_w, 2);
        check_eq("up2_ovf", ovf_w, 1);
        check_eq("up2_at_min", at_min_w, 1);
        check_eq("up2_at_max", at_max_w, 0);
        check_eq("up2_sat_count", count_s, 10);
        check_eq("up2_sat_ovf", ovf_s, 1);
        tick();
        check_eq("up3_count", count_w, 5);
        check_eq("up3_ovf", ovf_w, 0);
        check_eq("up3_at_min", at_min_w, 0);
        check_eq("up3_sat_ovf", ovf_s, 0);

        // Wrap down: 4 - 3 below min -> 10, unf
        do_load(8'd4);
        enable = 1'b1;
        up     = 1'b0;
        tick();
        check_eq("dn1_count", count_w, 10);
        check_eq("dn1_unf", unf_w, 1);
        check_eq("dn1_at_max", at_max_w, 1);
        tick();
        check_eq("dn2_count", count_w, 7);
        check_eq("dn2_unf", unf_w, 0);

        // Saturate up from 8
        do_load(8'd8);
        enable = 1'b1;
        up     = 1'b1;
        tick();
        check_eq("sat_up1_count", count_s, 10);
        check_eq("sat_up1_ovf", ovf_s, 1);
        tick();
        check_eq("sat_up2_count", count_s, 10);
        check_eq("sat_up2_ovf", ovf_s, 0);

        // Saturate down from 3
        do_load(8'd3);
        enable = 1'b1;
        up     = 1'b0;
        tick();
        check_eq("sat_dn1_count", count_s, 2);
        check_eq("sat_dn1_unf", unf_s, 1);
        tick();
        check_eq("sat_dn2_count", count_s, 2);
        check_eq("sat_dn2_unf", unf_s, 0);
        check_eq("sat_dn2_at_min", at_min_s, 1);

        // Load clamping and load priority over enable
        do_load(8'd200);
        check_eq("clamp_hi", count_w, 10);
        do_load(8'd0);
        check_eq("clamp_lo", count_w, 2);
        count_load = 1'b1;
        enable     = 1'b1;
        up         = 1'b1;
        load_value = 8'd6;
        tick();
        count_load = 1'b0;
        check_eq("load_en_count", count_w, 6);
        check_eq("load_en_ovf", ovf_w, 0);
        check_eq("load_en_unf", unf_w, 0);

        // step = 0 holds
        step = 8'd0;
        tick();
        check_eq("step0_count", count_w, 6);
        step = 8'd3;

        // Bad bounds freeze the counter
        min_value = 8'd12;
        #1;
        check_eq("cfg_err_set", cfg_err_w, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check_eq("cfg_hold_count", count_w, 6);
        check_eq("cfg_hold_ovf", ovf_w, 0);
        count_load = 1'b1;
        load_value = 8'd11;
        tick();
        count_load = 1'b0;
        check_eq("cfg_load_ignored", count_w, 6);
        min_value = 8'd2;
        #1;
        check_eq("cfg_err_clear", cfg_err_w, 0);

        // Max lowered beneath the count: clamp, no pulse
        do_load(8'd9);
        max_value = 8'd7;
        enable    = 1'b1;
        up        = 1'b1;
        tick();
        check_eq("shrink_count", count_w, 7);
        check_eq("shrink_ovf", ovf_w, 0);
        max_value = 8'd10;

        // min == max in wrap mode: every step pulses; flags back-to-back
        min_value = 8'd5;
        max_value = 8'd5;
        do_load(8'd9);
        enable = 1'b1;
        up     = 1'b1;
        step   = 8'd1;
        tick();
        check_eq("eq_up1_ovf", ovf_w, 1);
        tick();
        check_eq("eq_up2_count", count_w, 5);
        check_eq("eq_up2_ovf", ovf_w, 1);
        up = 1'b0;
        tick();
        check_eq("eq_dn_unf", unf_w, 1);
        check_eq("eq_dn_ovf", ovf_w, 0);
        min_value = 8'd2;
        max_value = 8'd10;
        step      = 8'd3;

        // Asynchronous reset mid-cycle with count = 7
        do_load(8'd7);
        check_eq("pre_rst_count", count_w, 7);
        #3;
        rst = 1'b0;
        #1;
        check_eq("async_rst_count", count_w, 0);
        check_eq("async_rst_ovf", ovf_w, 0);
        check_eq("async_rst_unf", unf_w, 0);
        rst = 1'b1;

        // Asynchronous reset clears a pending ovf pulse
        do_load(8'd9);
        enable = 1'b1;
        up     = 1'b1;
        tick();
        enable = 1'b0;
        check_eq("pre_rst_ovf", ovf_w, 1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("async_rst_ovf_clr", ovf_w, 0);
        rst = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
